// File: rtl/keypad_matrix_scanner.sv
`default_nettype none
// ----------------------------------------------------------------------------
// keypad_matrix_scanner: 4x4 keypad row scan, frame debounce, key code strobe
// Rev 1.0
// ----------------------------------------------------------------------------
module keypad_matrix_scanner #(
  parameter int unsigned SCAN_DIV       = 100000,
  parameter int unsigned DEBOUNCE_SCANS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned          c_ctr_w = $clog2(SCAN_DIV);
  localparam logic [c_ctr_w-1:0]   c_tc    = c_ctr_w'(SCAN_DIV - 1);
  localparam logic [3:0]           c_deb   = 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_PRESS_PEND = 2'd1,
    ST_HELD       = 2'd2
  } state_t;

  logic [3:0]         col_meta_q, col_meta_d;
  logic [3:0]         col_s_q, col_s_d;
  logic [c_ctr_w-1:0] ctr_q, ctr_d;
  logic [3:0]         row_q, row_d;
  logic [15:0]        frame_q, frame_d;
  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [3:0]         cand_q, cand_d;
  logic [3:0]         code_q, code_d;
  logic               valid_q, valid_d;
  logic               held_q, held_d;

  logic        tc;
  logic        row_legal;
  logic [1:0]  row_idx;
  logic [15:0] frame_w;
  logic        frame_end;
  logic [1:0]  n_set;
  logic [3:0]  hit_code;
  logic        is_none;
  logic        is_single;
  logic [3:0]  cnt_inc;

  always_comb begin
    tc        = (ctr_q == c_tc);
    row_legal = 1'b1;
    row_idx   = 2'd0;
    case (row_q)
      4'b1110: row_idx = 2'd0;
      4'b1101: row_idx = 2'd1;
      4'b1011: row_idx = 2'd2;
      4'b0111: row_idx = 2'd3;
      default: row_legal = 1'b0;
    endcase

    // Snapshot as it will look once the current row's sample is folded in
    frame_w = frame_q;
    if (row_legal) begin
      frame_w[{row_idx, 2'b00} +: 4] = ~col_s_q;
    end
    frame_end = tc && (row_q == 4'b0111);

    n_set    = 2'd0;
    hit_code = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (frame_w[i]) begin
        if (n_set != 2'd2) n_set = n_set + 2'd1;
        hit_code = 4'(i);
      end
    end
    is_none   = (n_set == 2'd0);
    is_single = (n_set == 2'd1);
    cnt_inc   = (cnt_q == c_deb) ? cnt_q : cnt_q + 4'd1;
  end

  always_comb begin
    col_meta_d = col_in;
    col_s_d    = col_meta_q;
    ctr_d      = tc ? '0 : ctr_q + c_ctr_w'(1);
    row_d      = row_q;
    frame_d    = frame_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    cand_d     = cand_q;
    code_d     = code_q;
    valid_d    = 1'b0;
    held_d     = held_q;

    if (tc) begin
      frame_d = frame_w;
      row_d   = row_legal ? {row_q[2:0], row_q[3]} : 4'b1110;
    end

    if (frame_end) begin
      case (state_q)
        ST_IDLE: begin
          if (is_single) begin
            cand_d = hit_code;
            if (c_deb == 4'd1) begin
              code_d  = hit_code;
              held_d  = 1'b1;
              valid_d = 1'b1;
              state_d = ST_HELD;
              cnt_d   = 4'd0;
            end else begin
              state_d = ST_PRESS_PEND;
              cnt_d   = 4'd1;
            end
          end
        end
        ST_PRESS_PEND: begin
          if (is_single) begin
            if (hit_code == cand_q) begin
              if (cnt_inc == c_deb) begin
                code_d  = cand_q;
                held_d  = 1'b1;
                valid_d = 1'b1;
                state_d = ST_HELD;
                cnt_d   = 4'd0;
              end else begin
                cnt_d = cnt_inc;
              end
            end else begin
              cand_d = hit_code;
              cnt_d  = 4'd1;
            end
          end else begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
          end
        end
        ST_HELD: begin
          // Any activity, even a different key, keeps the held key latched
          if (is_none) begin
            if (cnt_inc == c_deb) begin
              held_d  = 1'b0;
              state_d = ST_IDLE;
              cnt_d   = 4'd0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            cnt_d = 4'd0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_meta_q <= 4'b1111;
      col_s_q    <= 4'b1111;
      ctr_q      <= '0;
      row_q      <= 4'b1110;
      frame_q    <= 16'd0;
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      cand_q     <= 4'd0;
      code_q     <= 4'd0;
      valid_q    <= 1'b0;
      held_q     <= 1'b0;
    end else begin
      col_meta_q <= col_meta_d;
      col_s_q    <= col_s_d;
      ctr_q      <= ctr_d;
      row_q      <= row_d;
      frame_q    <= frame_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cand_q     <= cand_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      held_q     <= held_d;
    end
  end

  assign row_out   = row_q;
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_matrix_scanner.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_keypad_matrix_scanner: directed keypad scenarios with a key-event scoreboard
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_keypad_matrix_scanner;

  logic        clk;
  logic        rst;
  logic [3:0]  col_in;
  logic [3:0]  row_out;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;

  logic [15:0] keys;
  int          cyc;
  int          vectors;
  int          miscompares;
  int          obs_rd;
  int          obs_code[$];
  int          obs_cyc[$];
  int          exp_code[$];
  int          exp_cyc[$];
  logic [3:0]  rows [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  keypad_matrix_scanner #(
    .SCAN_DIV       (4),
    .DEBOUNCE_SCANS (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .col_in    (col_in),
    .row_out   (row_out),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Passive keypad: a pressed key shorts its column low while its row is driven
  always_comb begin
    col_in = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      if (!row_out[r]) begin
        for (int c = 0; c < 4; c++) begin
          if (keys[r*4 + c]) col_in[c] = 1'b0;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  always @(posedge clk) begin
    #2;
    if (key_valid === 1'b1) begin
      obs_code.push_back(int'(key_code));
      obs_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_frames(input int n);
    repeat (16 * n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_key(input int code, input int at_cyc);
    exp_code.push_back(code);
    exp_cyc.push_back(at_cyc);
  endtask

  task automatic check_valids(input string tag);
    int n_obs;
    n_obs = obs_code.size() - obs_rd;
    chk({tag, "_valid_count"}, n_obs, exp_code.size());
    for (int i = 0; i < n_obs && i < exp_code.size(); i++) begin
      chk({tag, "_valid_code"}, obs_code[obs_rd + i], exp_code[i]);
      chk({tag, "_valid_cycle"}, obs_cyc[obs_rd + i], exp_cyc[i]);
    end
    obs_rd = obs_code.size();
    exp_code.delete();
    exp_cyc.delete();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    obs_rd      = 0;
    rst         = 1'b1;
    keys        = 16'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    chk("rst_row_out", row_out, 4'b1110);
    chk("rst_key_code", key_code, 4'd0);
    chk("rst_key_valid", key_valid, 1'b0);
    chk("rst_key_held", key_held, 1'b0);

    for (int i = 0; i < 16; i++) begin
      chk("scan_row_out", row_out, rows[i/4]);
      @(negedge clk);
    end
    check_valids("idle");
    chk("idle_key_code", key_code, 4'd0);

    // Key 6: row 1, column 2; accepted at the end of the second frame
    keys[6] = 1'b1;
    expect_key(6, 48);
    run_frames(3);
    check_valids("press6");
    chk("press6_key_code", key_code, 4'd6);
    chk("press6_key_held", key_held, 1'b1);

    keys = 16'd0;
    run_frames(1);
    chk("rel6_held_after_1", key_held, 1'b1);
    run_frames(1);
    chk("rel6_held_after_2", key_held, 1'b0);
    chk("rel6_key_code", key_code, 4'd6);
    check_valids("rel6");

    keys[6] = 1'b1;
    run_frames(1);
    chk("bounce_held_a", key_held, 1'b0);
    keys = 16'd0;
    run_frames(1);
    keys[6] = 1'b1;
    run_frames(1);
    chk("bounce_held_b", key_held, 1'b0);
    keys = 16'd0;
    run_frames(1);
    chk("bounce_held_c", key_held, 1'b0);
    check_valids("bounce");

    keys = 16'h0021;
    run_frames(4);
    chk("multi_held", key_held, 1'b0);
    check_valids("multi");
    keys = 16'h0001;
    expect_key(0, 256);
    run_frames(2);
    check_valids("key0");
    chk("key0_key_code", key_code, 4'd0);
    chk("key0_key_held", key_held, 1'b1);
    keys = 16'd0;
    run_frames(2);
    chk("key0_release_held", key_held, 1'b0);

    keys[15] = 1'b1;
    expect_key(15, 320);
    run_frames(2);
    check_valids("key15");
    chk("key15_key_code", key_code, 4'd15);
    chk("key15_key_held", key_held, 1'b1);

    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_row_out", row_out, 4'b1110);
    chk("midrst_key_code", key_code, 4'd0);
    chk("midrst_key_valid", key_valid, 1'b0);
    chk("midrst_key_held", key_held, 1'b0);
    rst = 1'b0;
    expect_key(15, 32);
    run_frames(2);
    check_valids("rekey15");
    chk("rekey15_key_code", key_code, 4'd15);
    chk("rekey15_key_held", key_held, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/keypad_matrix_scanner.md
Name: keypad_matrix_scanner

Overview:
- Scans a 4x4 matrix keypad: drives rows one-hot active-low and samples active-low columns.
- Debounces the result and emits a 4-bit key code with a single-cycle valid strobe.
- Input-side counterpart of the multiplexed seven-segment display driver: same time-multiplexed, one-hot active-low rotation, but it decodes a pattern into a 4-bit value rather than encoding one.
- Feeds the stopwatch control logic (preset entry, start/stop/clear commands).

Parameters:
- SCAN_DIV, 100000, clock cycles each row is driven before the column sample and advance; must be >= 4.
- DEBOUNCE_SCANS, 3, consecutive identical full-scan frames needed to accept a press or a release; range 1..15.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- col_in  input  4  keypad columns, active-low, asynchronous to clk
- row_out  output  4  keypad row drive, one-hot active-low
- key_code  output  4  last accepted key, {row_idx[1:0], col_idx[1:0]}
- key_valid  output  1  one-cycle strobe when a new press is accepted
- key_held  output  1  high while the accepted key is considered pressed

Behaviour:
- Reset values:
  - row_out=4'b1110, key_code=0, key_valid=0, key_held=0.
  - Scan counter=0, state=IDLE, debounce count=0, candidate=0.
  - Both synchronizer stages=4'b1111.
- Synchronizer: col_in passes through 2 flops. The scan logic uses only the second stage (col_s).
- Scan counter:
  - Counts 0..SCAN_DIV-1 and wraps to 0.
  - Terminal count (TC) is ctr==SCAN_DIV-1.
- On TC:
  - Store ~col_s into the 4-bit slot of the current row in a 16-bit frame snapshot.
  - Advance row_out 1110->1101->1011->0111->1110.
  - Row index: 1110=0, 1101=1, 1011=2, 0111=3.
  - Any illegal row_out pattern goes to 1110 on the next TC.
  - Columns are never sampled in the cycle the row changes.
- Frame end: TC while row_out==0111. The snapshot, including this row's sample, is classified as:
  - NONE: 0 bits set.
  - SINGLE(code): exactly 1 bit set; code = row_idx*4 + col_idx, col_idx = bit position in col_in.
  - MULTI: 2 or more bits set (ghosting or rollover).
- State machine, evaluated only at frame end:
  - IDLE:
    - SINGLE(c): candidate=c, cnt=1.
    - If DEBOUNCE_SCANS==1, accept immediately. Otherwise go to PRESS_PEND.
    - NONE or MULTI: stay.
  - PRESS_PEND:
    - SINGLE(candidate): cnt++. When cnt reaches DEBOUNCE_SCANS, accept.
    - SINGLE(other): candidate=other, cnt=1.
    - NONE or MULTI: go to IDLE, cnt=0.
  - Accept: key_code<=candidate, key_held<=1, key_valid pulses, go to HELD, cnt=0.
  - HELD:
    - NONE: cnt++. When cnt reaches DEBOUNCE_SCANS, key_held<=0, go to IDLE.
    - SINGLE (any code) or MULTI: cnt=0, stay.
    - No new key_valid is issued until a debounced release occurs. A roll-over to a different key requires release first.
- Timing of outputs:
  - key_valid is registered: high for exactly 1 cycle, the cycle after the accepting frame-end TC.
  - key_code and key_held update on that same edge.
  - key_code holds its value after release until the next accept.
- Latency: a clean press present from the start of a frame is accepted DEBOUNCE_SCANS frames later, i.e. DEBOUNCE_SCANS*4*SCAN_DIV cycles, plus synchronizer delay.
- Counter widths: scan counter sized by $clog2(SCAN_DIV); debounce counter 4 bits, saturating at DEBOUNCE_SCANS.
- Reset mid-operation: all state returns to reset values on the next clk edge. A key pressed across reset is re-debounced from IDLE.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=2, frame=16 cycles):
- Reset release, col_in=1111 -> row_out sequence 1110,1101,1011,0111 with each row lasting 4 cycles; key_valid never asserts; key_code=0.
- Hold col_in=1011 only while row_out==1101 for 3 frames -> key_code=6, exactly one key_valid pulse, key_valid at end of frame 2; key_held=1.
- Release the same key for 2 frames -> key_held falls after the 2nd empty frame; key_code stays 6; no key_valid.
- Bounce: key 6 present 1 frame, absent 1, present 1, absent -> no key_valid, key_held stays 0.
- Keys 0 and 5 pressed together for 4 frames (MULTI) -> no accept. Release key 5 so only key 0 remains for 2 frames -> key_code=0, one key_valid pulse.
- Accept key 15 (col_in=0111 on row 0111). Assert rst for 1 cycle mid-frame while still held -> all outputs return to reset values. Key 15 is re-accepted after 2 full frames with a new key_valid pulse.
